// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed N-digit hex 7-segment driver with frame-synchronous loads,
// leading-zero blanking and PWM dimming. Optional per-digit blink under SEG7_BLINK_EN.
module seg7_scan_ctrl #(
    parameter int unsigned N_DIGITS   = 8,
    parameter int unsigned SCAN_LOG2  = 12,
    parameter int unsigned DIM_BITS   = 3,
    parameter int unsigned BLINK_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] data,
    input  logic [N_DIGITS-1:0]   dp,
    input  logic [N_DIGITS-1:0]   digit_en,
`ifdef SEG7_BLINK_EN
    input  logic [N_DIGITS-1:0]   blink,
`endif
    input  logic                  lz_blank,
    input  logic                  load,
    output logic                  load_ack,
    input  logic [DIM_BITS-1:0]   brightness,
    output logic                  frame_tick,
    output logic [N_DIGITS-1:0]   an,
    output logic [7:0]            seg
);
    localparam int unsigned IDX_W = $clog2(N_DIGITS);

    typedef struct packed {
        logic [4*N_DIGITS-1:0] data;
        logic [N_DIGITS-1:0]   dp;
        logic [N_DIGITS-1:0]   en;
`ifdef SEG7_BLINK_EN
        logic [N_DIGITS-1:0]   blink;
`endif
        logic                  lz;
    } disp_t;

    logic [SCAN_LOG2-1:0] presc_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 slot_tick;
    logic                 wrap;

    disp_t in_cfg;
    disp_t pend_q, pend_d;
    disp_t disp_q, disp_d;
    logic  pend_valid_q, pend_valid_d;

    logic [N_DIGITS-1:0] upper_zero;
    logic                zero_run;
    logic [3:0]          cur_nib;
    logic                blink_ok;
    logic                lit;
    logic [N_DIGITS-1:0] an_d;
    logic [7:0]          seg_d;

    assign slot_tick = &presc_q;
    assign wrap      = slot_tick && (idx_q == IDX_W'(N_DIGITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
            if (slot_tick) begin
                idx_q <= wrap ? '0 : idx_q + 1'b1;
            end
        end
    end

    always_comb begin
        in_cfg.data = data;
        in_cfg.dp   = dp;
        in_cfg.en   = digit_en;
`ifdef SEG7_BLINK_EN
        in_cfg.blink = blink;
`endif
        in_cfg.lz   = lz_blank;
    end

    // A load landing on the wrapping tick bypasses the pending regs and is applied directly.
    always_comb begin
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        disp_d       = disp_q;
        if (wrap) begin
            if (load) begin
                disp_d = in_cfg;
            end else if (pend_valid_q) begin
                disp_d = pend_q;
            end
            pend_valid_d = 1'b0;
        end else if (load) begin
            pend_d       = in_cfg;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            disp_q       <= '0;
        end else begin
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            disp_q       <= disp_d;
        end
    end

`ifdef SEG7_BLINK_EN
    localparam int unsigned BCNT_W = (BLINK_LOG2 > 0) ? BLINK_LOG2 : 1;
    logic [BCNT_W-1:0] blink_cnt_q;
    logic              blink_on_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else if (wrap) begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
            if ((BLINK_LOG2 == 0) || (&blink_cnt_q)) begin
                blink_on_q <= ~blink_on_q;
            end
        end
    end

    assign blink_ok = ~(disp_q.blink[idx_q] & ~blink_on_q);
`else
    assign blink_ok = 1'b1;
`endif

    // upper_zero[i]: nibbles i..N_DIGITS-1 of the displayed value are all zero.
    always_comb begin
        zero_run   = 1'b1;
        upper_zero = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_run      = zero_run && (disp_q.data[4*i +: 4] == 4'h0);
            upper_zero[i] = zero_run;
        end
    end

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    assign cur_nib = disp_q.data[{idx_q, 2'b00} +: 4];
    assign lit     = (presc_q[SCAN_LOG2-1 -: DIM_BITS] <= brightness) && disp_q.en[idx_q]
                     && blink_ok;

    always_comb begin
        an_d  = '1;
        seg_d = 8'hFF;
        if (lit) begin
            an_d[idx_q] = 1'b0;
            seg_d[7]    = ~disp_q.dp[idx_q];
            if (disp_q.lz && (idx_q != '0) && upper_zero[idx_q]) begin
                seg_d[6:0] = 7'h7F;
            end else begin
                seg_d[6:0] = hex_glyph(cur_nib);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an         <= '1;
            seg        <= 8'hFF;
            load_ack   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_d;
            seg        <= seg_d;
            load_ack   <= wrap && (load || pend_valid_q);
            frame_tick <= wrap;
        end
    end

endmodule
